sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller host port between four requesters:
  - ch0 VGA line-fetch DMA
  - ch1 CPU
  - ch2 SPI/SD DMA
  - ch3 audio/aux DMA
- ch0 has fixed top priority; ch1-ch3 are round-robin.
- One transaction outstanding at a time: single word, read or write.
- Sits between the peripheral DMA engines and the SDRAM controller, clocked at system clock (100 MHz).

Parameters:
- ADDR_W, 24, word-address width of requester and SDRAM ports.
- DATA_W, 16, data width.
- TIMEOUT, 255, cycles to wait for sdram_ack before abandoning a transaction (8-bit counter, legal 1..255).
- STARVE_LIMIT, 8, ch0 grants allowed in a row while ch1-3 wait (optional feature only).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  4  per-channel request, level, bit n = ch n.
- wr  in  4  per-channel write flag (1 = write), valid while req[n].
- addr  in  4*ADDR_W  packed addresses, ch n at [n*ADDR_W +: ADDR_W].
- wdata  in  4*DATA_W  packed write data.
- ack  out  4  one-cycle completion pulse per channel.
- rdata  out  DATA_W  registered read data, valid on any ack pulse.
- err  out  4  sticky per-channel timeout flag.
- sdram_req  out  1  request to SDRAM controller, held until sdram_ack.
- sdram_wr  out  1  write flag to controller.
- sdram_addr  out  ADDR_W  address to controller.
- sdram_wdata  out  DATA_W  write data to controller.
- sdram_ack  in  1  one-cycle completion pulse from controller.
- sdram_rdata  in  DATA_W  read data, valid with sdram_ack.
- grant  out  2  index of the current or last-served channel (debug/LEDs).

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = ch1; timeout counter 0; starve counter 0.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req is set: choose the winner, register grant and the winner's addr/wr/wdata onto the sdram_* outputs, go to ISSUE.
  - Winner is ch0 if req[0]; otherwise the first set bit among ch1-3, searching from the RR pointer and wrapping 3 -> 1.
- ISSUE: sdram_req = 1, clear the timeout counter, go to WAIT.
- WAIT:
  - sdram_req stays 1; address, data and wr are stable.
  - Each cycle without sdram_ack, the counter increments.
  - On sdram_ack: sdram_req = 0; ack[grant] pulses 1 for the next cycle only; rdata <= sdram_rdata (also latched for writes); if grant != 0, RR pointer = grant+1 (wrapping 3 -> 1); go to IDLE.
  - Timeout: when the counter reaches TIMEOUT with no sdram_ack, set err[grant], pulse ack[grant] with rdata = 0, drop sdram_req, go to IDLE.
- Latency: req sampled in IDLE -> sdram_req asserted 2 cycles later. sdram_ack -> ack 1 cycle later. Minimum gap between transactions is 1 IDLE cycle.
- Requester rules:
  - Hold req, addr, wr and wdata stable until ack.
  - Clear req on the edge where ack = 1, or keep it high to request again; a held req is re-arbitrated as a new request.
- Changes to a non-granted channel's inputs have no effect.
- req dropped by the granted channel mid-transaction: the transaction still completes and ack still pulses.
- Simultaneous requests on all four channels: ch0 wins; then ch1, ch2, ch3 in RR order on later IDLE cycles.
- sdram_ack outside WAIT is ignored.
- err[n] clears only on reset.
- Reset asserted mid-transaction: outputs go to reset values immediately (asynchronous); no ack is issued.

Optional Feature:
- Macro: SDRAM_ARB_STARVE_EN.
- When defined:
  - The starve counter increments on each ch0 grant made while any of req[3:1] is set, and clears on any ch1-3 grant.
  - When it equals STARVE_LIMIT, the next IDLE arbitration ignores req[0] and serves the RR winner.
- When undefined: strict ch0 priority, no counter logic.

Test Plan:
- Single read: ch1 req, addr=0x000123, wr=0; controller acks 5 cycles after sdram_req with rdata=0xBEEF -> sdram_addr=0x000123, sdram_wr=0; ack[1] pulses once; rdata=0xBEEF; grant=1.
- Single write: ch2 req, wr=1, wdata=0x5A5A -> sdram_wr=1, sdram_wdata=0x5A5A held until sdram_ack; ack[2] pulses once.
- Priority/RR: req=4'b1111 held, each channel drops req on its ack -> service order ch0, ch1, ch2, ch3. Then req=4'b1110 re-raised with pointer at ch1 -> order ch1, ch2, ch3.
- Timeout: ch3 req, sdram_ack never asserted -> after 255 WAIT cycles err=4'b1000, ack[3] pulses with rdata=0, sdram_req=0; next ch1 request is served normally.
- Reset mid-WAIT: reset_n low while sdram_req=1 -> sdram_req, ack and err = 0 in the same cycle; no ack after release.
- With SDRAM_ARB_STARVE_EN and STARVE_LIMIT=8: req[0] and req[1] held continuously -> 8 ch0 grants, then 1 ch1 grant, pattern repeats. Without the macro: ch0 only.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares the single-word SDRAM controller host port between
// four requesters (ch0 VGA DMA, ch1 CPU, ch2 SPI/SD DMA, ch3 audio/aux DMA).
// ch0 has fixed priority, ch1-ch3 are served round-robin, and one transaction is
// in flight at a time. Optional build macro SDRAM_ARB_STARVE_EN bounds the number
// of back-to-back ch0 grants while any of ch1-ch3 is waiting.
module sdram_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 16,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          req,
    input  logic [3:0]          wr,
    input  logic [4*ADDR_W-1:0] addr,
    input  logic [4*DATA_W-1:0] wdata,
    output logic [3:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic [3:0]          err,
    output logic                sdram_req,
    output logic                sdram_wr,
    output logic [ADDR_W-1:0]   sdram_addr,
    output logic [DATA_W-1:0]   sdram_wdata,
    input  logic                sdram_ack,
    input  logic [DATA_W-1:0]   sdram_rdata,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    // Timeout fires on the WAIT cycle whose increment would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q;
    logic [1:0]          rr_ptr_q;
    logic [7:0]          tmo_q;
    logic [1:0]          grant_q;
    logic                sdram_req_q;
    logic                sdram_wr_q;
    logic [ADDR_W-1:0]   sdram_addr_q;
    logic [DATA_W-1:0]   sdram_wdata_q;
    logic [3:0]          ack_q;
    logic [3:0]          err_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          cand_d;
    logic [1:0]          rr_win_d;
    logic                rr_hit_d;
    logic                use_ch0_d;
    logic [1:0]          win_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wr_d;

`ifdef SDRAM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q;
`endif

    // Round-robin successor within ch1..ch3 (3 wraps to 1).
    function automatic logic [1:0] next_rr(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    // Winner selection and mux of the winner's request fields.
    always_comb begin
        cand_d   = rr_ptr_q;
        rr_win_d = 2'd1;
        rr_hit_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!rr_hit_d && req[cand_d]) begin
                rr_hit_d = 1'b1;
                rr_win_d = cand_d;
            end
            cand_d = next_rr(cand_d);
        end
        use_ch0_d = req[0] | ~rr_hit_d;
`ifdef SDRAM_ARB_STARVE_EN
        if ((starve_q == STARVE_W'(STARVE_LIMIT)) && rr_hit_d) begin
            use_ch0_d = 1'b0;
        end
`endif
        win_d   = use_ch0_d ? 2'd0 : rr_win_d;
        addr_d  = addr[win_d*ADDR_W +: ADDR_W];
        wdata_d = wdata[win_d*DATA_W +: DATA_W];
        wr_d    = wr[win_d];
    end

    // Transaction FSM: arbitrate, issue, wait for completion or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 2'd1;
            tmo_q         <= '0;
            grant_q       <= '0;
            sdram_req_q   <= 1'b0;
            sdram_wr_q    <= 1'b0;
            sdram_addr_q  <= '0;
            sdram_wdata_q <= '0;
            ack_q         <= '0;
            err_q         <= '0;
            rdata_q       <= '0;
`ifdef SDRAM_ARB_STARVE_EN
            starve_q      <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q       <= win_d;
                        sdram_addr_q  <= addr_d;
                        sdram_wdata_q <= wdata_d;
                        sdram_wr_q    <= wr_d;
                        state_q       <= ISSUE;
`ifdef SDRAM_ARB_STARVE_EN
                        if (win_d == 2'd0) begin
                            if ((|req[3:1]) && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
                                starve_q <= starve_q + 1'b1;
                            end
                        end else begin
                            starve_q <= '0;
                        end
`endif
                    end
                end
                ISSUE: begin
                    sdram_req_q <= 1'b1;
                    tmo_q       <= '0;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (sdram_ack) begin
                        sdram_req_q    <= 1'b0;
                        ack_q[grant_q] <= 1'b1;
                        rdata_q        <= sdram_rdata;
                        if (grant_q != 2'd0) begin
                            rr_ptr_q <= next_rr(grant_q);
                        end
                        state_q <= IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        sdram_req_q    <= 1'b0;
                        ack_q[grant_q] <= 1'b1;
                        err_q[grant_q] <= 1'b1;
                        rdata_q        <= '0;
                        state_q        <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack         = ack_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign sdram_req   = sdram_req_q;
    assign sdram_wr    = sdram_wr_q;
    assign sdram_addr  = sdram_addr_q;
    assign sdram_wdata = sdram_wdata_q;
    assign grant       = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed scenarios with a transaction-level
// reference model compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;

    localparam int ADDR_W       = 24;
    localparam int DATA_W       = 16;
    localparam int TIMEOUT      = 255;
    localparam int STARVE_LIMIT = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [3:0]          req;
    logic [3:0]          wr;
    logic [4*ADDR_W-1:0] addr;
    logic [4*DATA_W-1:0] wdata;
    logic [3:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic [3:0]          err;
    logic                sdram_req;
    logic                sdram_wr;
    logic [ADDR_W-1:0]   sdram_addr;
    logic [DATA_W-1:0]   sdram_wdata;
    logic                sdram_ack;
    logic [DATA_W-1:0]   sdram_rdata;
    logic [1:0]          grant;

    sdram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .sdram_req(sdram_req), .sdram_wr(sdram_wr),
        .sdram_addr(sdram_addr), .sdram_wdata(sdram_wdata), .sdram_ack(sdram_ack),
        .sdram_rdata(sdram_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Bench-side requester/controller behaviour knobs.
    logic [3:0]        drop_on_ack;
    int                ack_delay;
    int                ctl_cnt;
    logic [DATA_W-1:0] ctl_rdata;
    int                served[$];

    // ---------------- reference model (transaction timestamps) ----------------
    bit                m_busy;
    int                m_cyc;
    int                m_tarb;
    int                m_ptr;
    int                m_starve;
    int                m_w;
    int                m_c;
    logic [1:0]        m_grant;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_wr;
    logic [3:0]        m_ack;
    logic [3:0]        m_err;
    logic [DATA_W-1:0] m_rdata;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_tarb = 0; m_ptr = 1; m_starve = 0;
            m_grant = '0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
            m_ack = '0; m_err = '0; m_rdata = '0;
        end else begin
            m_cyc = m_cyc + 1;
            m_ack = '0;
            if (m_busy) begin
                if ((m_cyc >= m_tarb + 2) && sdram_ack) begin
                    m_ack[m_grant] = 1'b1;
                    m_rdata = sdram_rdata;
                    if (m_grant != 0) m_ptr = (int'(m_grant) % 3) + 1;
                    m_busy = 1'b0;
                end else if (m_cyc - m_tarb - 1 == TIMEOUT) begin
                    m_ack[m_grant] = 1'b1;
                    m_err[m_grant] = 1'b1;
                    m_rdata = '0;
                    m_busy = 1'b0;
                end
            end else if (req != 4'd0) begin
                m_w = -1;
                if (req[0]) m_w = 0;
`ifdef SDRAM_ARB_STARVE_EN
                if (m_starve == STARVE_LIMIT && req[3:1] != 3'd0) m_w = -1;
`endif
                for (int k = 0; k < 3; k++) begin
                    m_c = ((m_ptr - 1 + k) % 3) + 1;
                    if (m_w < 0 && req[m_c]) m_w = m_c;
                end
`ifdef SDRAM_ARB_STARVE_EN
                if (m_w == 0) begin
                    if (req[3:1] != 3'd0) m_starve = m_starve + 1;
                end else begin
                    m_starve = 0;
                end
`endif
                m_busy  = 1'b1;
                m_tarb  = m_cyc;
                m_grant = 2'(m_w);
                m_addr  = addr[m_w*ADDR_W +: ADDR_W];
                m_wdata = wdata[m_w*DATA_W +: DATA_W];
                m_wr    = wr[m_w];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_sreq;
        exp_sreq = m_busy && (m_cyc >= m_tarb + 1);
        check("model sdram_req",   32'(sdram_req),   32'(exp_sreq));
        check("model sdram_addr",  32'(sdram_addr),  32'(m_addr));
        check("model sdram_wr",    32'(sdram_wr),    32'(m_wr));
        check("model sdram_wdata", 32'(sdram_wdata), 32'(m_wdata));
        check("model ack",         32'(ack),         32'(m_ack));
        check("model rdata",       32'(rdata),       32'(m_rdata));
        check("model err",         32'(err),         32'(m_err));
        check("model grant",       32'(grant),       32'(m_grant));
    endtask

    // One clock: compare just after the edge, then act as requesters and controller.
    task automatic tick();
        @(posedge clk);
        #1;
        compare_model();
        for (int n = 0; n < 4; n++) begin
            if (ack[n]) begin
                served.push_back(n);
                if (drop_on_ack[n]) req[n] = 1'b0;
            end
        end
        if (sdram_ack) begin
            sdram_ack = 1'b0;
            ctl_cnt   = 0;
        end else if (sdram_req && ack_delay > 0) begin
            ctl_cnt++;
            if (ctl_cnt >= ack_delay) begin
                sdram_ack   = 1'b1;
                sdram_rdata = ctl_rdata;
            end
        end else begin
            ctl_cnt = 0;
        end
    endtask

    task automatic wait_sreq(input int budget, output int cycles);
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (sdram_req) begin
                cycles = i;
                return;
            end
        end
        n_vec++; n_fail++;
        $display("FAIL wait_sreq: sdram_req not seen within %0d cycles", budget);
        cycles = -1;
    endtask

    task automatic wait_ack(input int ch, input int budget, output int cycles);
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ack[ch]) begin
                cycles = i;
                return;
            end
        end
        n_vec++; n_fail++;
        $display("FAIL wait_ack ch%0d: no ack within %0d cycles", ch, budget);
        cycles = -1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int cyc;
        int nack;
        int exp_order[4];
        reset_n = 1'b0; req = '0; wr = '0; addr = '0; wdata = '0;
        sdram_ack = 1'b0; sdram_rdata = '0; drop_on_ack = '0;
        ack_delay = 0; ctl_cnt = 0; ctl_rdata = '0; m_cyc = 0;

        // Reset state
        repeat (3) tick();
        check("reset sdram_req", 32'(sdram_req), 32'h0);
        check("reset ack",       32'(ack),       32'h0);
        check("reset err",       32'(err),       32'h0);
        check("reset grant",     32'(grant),     32'h0);
        check("reset rdata",     32'(rdata),     32'h0);
        reset_n = 1'b1;
        tick();

        // Single read on ch1
        addr[1*ADDR_W +: ADDR_W] = 24'h000123;
        wr[1] = 1'b0; drop_on_ack = 4'b1111; ack_delay = 5; ctl_rdata = 16'hBEEF;
        req[1] = 1'b1;
        wait_sreq(20, cyc);
        check("read req->sdram_req latency", 32'(cyc), 32'd2);
        check("read sdram_addr", 32'(sdram_addr), 32'h000123);
        check("read sdram_wr",   32'(sdram_wr),   32'h0);
        check("read grant",      32'(grant),      32'h1);
        wait_ack(1, 50, cyc);
        check("read ack latency", 32'(cyc), 32'd5);
        check("read ack",   32'(ack),   32'h2);
        check("read rdata", 32'(rdata), 32'hBEEF);
        tick();
        check("read ack one pulse", 32'(ack), 32'h0);

        // Single write on ch2; granted channel drops req mid-flight, ch3 inputs wiggle
        addr[2*ADDR_W +: ADDR_W]  = 24'h00ABCD;
        wdata[2*DATA_W +: DATA_W] = 16'h5A5A;
        wr[2] = 1'b1; ack_delay = 6; ctl_rdata = 16'h1111;
        req[2] = 1'b1;
        wait_sreq(20, cyc);
        req[2] = 1'b0;
        addr[3*ADDR_W +: ADDR_W]  = 24'hFFFFFF;
        wdata[3*DATA_W +: DATA_W] = 16'hDEAD;
        wr[3] = 1'b1;
        tick();
        check("write sdram_wr",    32'(sdram_wr),    32'h1);
        check("write sdram_wdata", 32'(sdram_wdata), 32'h5A5A);
        check("write sdram_addr",  32'(sdram_addr),  32'h00ABCD);
        wait_ack(2, 50, cyc);
        check("write ack",   32'(ack),   32'h4);
        check("write rdata", 32'(rdata), 32'h1111);
        tick();

        // Priority then round-robin from a fresh pointer
        do_reset();
        for (int n = 0; n < 4; n++) begin
            addr[n*ADDR_W +: ADDR_W]  = 24'(32'h100 * (n + 1));
            wdata[n*DATA_W +: DATA_W] = 16'(32'h0A0 + n);
        end
        wr = 4'b0101; ack_delay = 3; ctl_rdata = 16'h3C3C;
        served.delete();
        req = 4'b1111;
        for (int i = 0; i < 200 && served.size() < 4; i++) tick();
        exp_order = '{0, 1, 2, 3};
        check("rr1 count", 32'(served.size()), 32'd4);
        for (int i = 0; i < 4 && i < served.size(); i++)
            check($sformatf("rr1 order[%0d]", i), 32'(served[i]), 32'(exp_order[i]));
        tick();
        served.delete();
        req = 4'b1110;
        for (int i = 0; i < 200 && served.size() < 3; i++) tick();
        exp_order = '{1, 2, 3, 0};
        check("rr2 count", 32'(served.size()), 32'd3);
        for (int i = 0; i < 3 && i < served.size(); i++)
            check($sformatf("rr2 order[%0d]", i), 32'(served[i]), 32'(exp_order[i]));
        tick();

        // Timeout on ch3, then a normal ch1 read
        ack_delay = 0;
        req[3] = 1'b1;
        wait_sreq(20, cyc);
        wait_ack(3, 400, cyc);
        check("timeout sdram_req cycles", 32'(cyc), 32'd255);
        check("timeout err",       32'(err),       32'h8);
        check("timeout ack",       32'(ack),       32'h8);
        check("timeout rdata",     32'(rdata),     32'h0);
        check("timeout sdram_req", 32'(sdram_req), 32'h0);
        tick();
        ack_delay = 2; ctl_rdata = 16'h7777;
        req[1] = 1'b1;
        wait_ack(1, 50, cyc);
        check("post-timeout ack",   32'(ack),   32'h2);
        check("post-timeout rdata", 32'(rdata), 32'h7777);
        check("post-timeout err",   32'(err),   32'h8);
        tick();

        // Stray sdram_ack while idle
        sdram_ack = 1'b1;
        tick();
        tick();
        check("stray ack ignored", 32'(ack),       32'h0);
        check("stray no sdram_req", 32'(sdram_req), 32'h0);

        // Reset in the middle of WAIT
        ack_delay = 0;
        req[2] = 1'b1;
        wait_sreq(20, cyc);
        repeat (3) tick();
        reset_n = 1'b0;
        req = '0;
        #1;
        check("async reset sdram_req", 32'(sdram_req), 32'h0);
        check("async reset ack",       32'(ack),       32'h0);
        check("async reset err",       32'(err),       32'h0);
        tick();
        reset_n = 1'b1;
        nack = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack != 4'd0) nack++;
        end
        check("no ack after reset", 32'(nack), 32'd0);

        // ch0 and ch1 held continuously
        served.delete();
        drop_on_ack = 4'b0000; ack_delay = 1; ctl_rdata = 16'h0F0F;
        req = 4'b0011;
        for (int i = 0; i < 400 && served.size() < 18; i++) tick();
        req = '0;
        check("hold count", 32'(served.size()), 32'd18);
        for (int i = 0; i < 18 && i < served.size(); i++) begin
`ifdef SDRAM_ARB_STARVE_EN
            check($sformatf("hold order[%0d]", i), 32'(served[i]), ((i % 9) == 8) ? 32'd1 : 32'd0);
`else
            check($sformatf("hold order[%0d]", i), 32'(served[i]), 32'd0);
`endif
        end
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
